proc_sequencer: RTL and testbench
=================================

Name: proc_sequencer

Overview:
- Multi-cycle instruction sequencer for the 16-bit enhanced processor datapath: R0–R6, PC as R7, A, G, the bus mux and the add/sub unit.
- Runs the fetch/decode/execute loop: PC-driven fetch over a memory-ready handshake, then per-opcode execute micro-steps that drive mux selects and register load enables.
- Adds load/store, a memory wait timeout and optional conditional branching.

Parameters:
- MEM_TIMEOUT, 15: max consecutive cycles spent waiting for mem_ready before aborting.
- SEL_W, 4: width of the bus-mux select.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset, sampled on rising clk.
- run  in  1  start/continue execution.
- IR_out  in  16  instruction register contents.
- mem_ready  in  1  memory data valid / write accepted.
- flag_z  in  1  datapath zero flag.
- flag_c  in  1  datapath carry flag.
- sel  out  SEL_W  bus mux select: 0–7 = R0–R7, 8 = IR imm9 zero-extended, 9 = G, 10 = DIN, 11 = IR[7:0]<<8.
- RX_in  out  8  one-hot register load, bit 7 = PC.
- IR_in, A_in, G_in  out  1  register loads.
- add_sub_ctrl  out  1  1 = subtract.
- pc_incr  out  1  single-cycle PC increment pulse.
- ADDR_in  out  1  load memory address register from bus.
- DOUT_in  out  1  load memory data-out register from bus.
- W_D  out  1  memory write strobe.
- done  out  1  one-cycle instruction-complete pulse.
- err  out  1  sticky memory timeout flag.

Behaviour:
- Instruction format: IR[15:13] = op, IR[12] = M (1 = immediate), IR[11:9] = X, IR[8:0] = Y field / imm9 (Y = IR[2:0]).
- Opcodes: 000 mv, 001 mvt, 010 add, 011 sub, 100 ld, 101 st, 110 reserved (treated as no-op, done asserted in E1), 111 b.
- All outputs are decoded from state and IR_out. Every output is 0 in IDLE and on the cycle after reset_n is sampled low. Reset takes effect from any state, mid-instruction included; err clears only on reset.
- States: IDLE, F0, F1, F2, E1, E2, E3.
- IDLE: leave to F0 when run=1.
- F0: sel=7, ADDR_in=1, pc_incr=1 → F1.
- F1: wait for mem_ready=1, then → F2.
- F2: IR_in=1 (bus ignored) → E1.
- mv: E1 sel = M ? 8 : Y, RX_in[X]=1, done.
- mvt: E1 sel=11, RX_in[X]=1, done.
- add/sub:
  - E1 sel=X, A_in.
  - E2 sel = M ? 8 : Y, G_in, add_sub_ctrl = (op==011).
  - E3 sel=9, RX_in[X], done.
- ld:
  - E1 sel=Y, ADDR_in.
  - E2 wait for mem_ready.
  - E3 sel=10, RX_in[X], done.
- st:
  - E1 sel=Y, ADDR_in.
  - E2 sel=X, DOUT_in, W_D held until mem_ready=1; done on the cycle mem_ready=1.
- b: E1, if taken, sel=8, RX_in[7]=1; done either way.
- After done: run=1 → F0, else → IDLE. run is sampled only in IDLE and on done cycles.
- Writes with X=7 are legal for mv, mvt, add, sub and ld (jump via register). pc_incr never coincides with RX_in[7].
- Wait counter:
  - Counts cycles in F1, ld-E2 and st-E2 while mem_ready=0; clears on state entry.
  - When it reaches MEM_TIMEOUT with mem_ready still 0: err=1 next cycle, state → IDLE, no done.
  - mem_ready=1 on the same cycle as the count reaching MEM_TIMEOUT wins (normal progress).
- Latency with mem_ready held at 1: mv/mvt/b = 4 cycles, st = 5, add/sub/ld = 6.

Optional Feature:
- Macro: COND_BRANCH_EN.
- Defined: b uses X as condition:
  - 000 always
  - 001 eq (flag_z=1)
  - 010 ne (flag_z=0)
  - 011 cc (flag_c=0)
  - 100 cs (flag_c=1)
  - 101–111 never taken
  - Flags are sampled in E1.
- Undefined: every b is unconditional; flag_z and flag_c are unused.

Test Plan:
- Reset, run=1, mem_ready=1, IR_out=0x1405 (mv R2,#5) → F0: sel=7, ADDR_in=1, pc_incr=1; F2: IR_in=1; E1: sel=8, RX_in=8'h04, done=1.
- IR_out=0x4202 (add R1,R2) → E1: sel=1, A_in; E2: sel=2, G_in, add_sub_ctrl=0; E3: sel=9, RX_in=8'h02, done. With 0x6202 (sub), add_sub_ctrl=1 in E2.
- IR_out=0x8604 (ld R3,[R4]), mem_ready low 3 cycles in E2 → E2 held 3 extra cycles; then E3: sel=10, RX_in=8'h08, done.
- mem_ready held low in F1 → err=1 after 15 wait cycles, state IDLE, done never pulses, outputs 0; err stays 1 until reset.
- COND_BRANCH_EN, IR_out=0xE210 (beq 0x010): flag_z=0 → RX_in=0, done=1; flag_z=1 → sel=8, RX_in=8'h80, done=1.
- reset_n low during E2 of add → next cycle all outputs 0, state IDLE; after release with run=1, fetch restarts at F0.

Source files
------------

// File: rtl/proc_sequencer_if.sv
// Sequencer <-> datapath control bundle: instruction/flags/memory-ready in,
// bus-mux select and register/memory strobes out.
interface proc_sequencer_if #(
  parameter int unsigned SEL_W = 4
);
  logic [15:0]      IR_out;
  logic             mem_ready;
  logic             flag_z;
  logic             flag_c;
  logic [SEL_W-1:0] sel;
  logic [7:0]       RX_in;
  logic             IR_in;
  logic             A_in;
  logic             G_in;
  logic             add_sub_ctrl;
  logic             pc_incr;
  logic             ADDR_in;
  logic             DOUT_in;
  logic             W_D;
  logic             done;
  logic             err;

  modport master (
    input  IR_out, mem_ready, flag_z, flag_c,
    output sel, RX_in, IR_in, A_in, G_in, add_sub_ctrl, pc_incr,
           ADDR_in, DOUT_in, W_D, done, err
  );

  modport slave (
    output IR_out, mem_ready, flag_z, flag_c,
    input  sel, RX_in, IR_in, A_in, G_in, add_sub_ctrl, pc_incr,
           ADDR_in, DOUT_in, W_D, done, err
  );
endinterface

// File: rtl/proc_sequencer.sv
// Fetch/decode/execute sequencer with load/store and memory-wait timeout.
// Define COND_BRANCH_EN to make b conditional on flag_z/flag_c (X = condition).
module proc_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned SEL_W       = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  proc_sequencer_if.master bus
);

  localparam int unsigned CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned SEL_PC   = 7;
  localparam int unsigned SEL_IMM  = 8;
  localparam int unsigned SEL_G    = 9;
  localparam int unsigned SEL_DIN  = 10;
  localparam int unsigned SEL_HI   = 11;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_LD  = 3'b100;
  localparam logic [2:0] OP_ST  = 3'b101;
  localparam logic [2:0] OP_B   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_E1, S_E2, S_E3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, cnt_nxt;
  logic             err_q;
  logic             timeout;

  logic [2:0]       op, x, y;
  logic             m;
  logic             taken;
  logic [SEL_W-1:0] sel_y;
  logic [7:0]       rx_x;
  logic             mem_wait;
  logic             wait_expired;

  logic [SEL_W-1:0] sel_c;
  logic [7:0]       rx_c;
  logic             ir_in_c, a_in_c, g_in_c, add_sub_c, pc_incr_c;
  logic             addr_in_c, dout_in_c, w_d_c, done_c;

  assign op    = bus.IR_out[15:13];
  assign m     = bus.IR_out[12];
  assign x     = bus.IR_out[11:9];
  assign y     = bus.IR_out[2:0];
  assign sel_y = m ? SEL_W'(SEL_IMM) : SEL_W'(y);
  assign rx_x  = 8'b1 << x;

  // imm9 itself is routed inside the datapath; only its select code lives here
  logic unused_imm;
  assign unused_imm = ^bus.IR_out[8:3];

`ifdef COND_BRANCH_EN
  always_comb begin
    case (x)
      3'b000:  taken = 1'b1;
      3'b001:  taken = bus.flag_z;
      3'b010:  taken = ~bus.flag_z;
      3'b011:  taken = ~bus.flag_c;
      3'b100:  taken = bus.flag_c;
      default: taken = 1'b0;
    endcase
  end
`else
  logic unused_flags;
  assign taken        = 1'b1;
  assign unused_flags = bus.flag_z ^ bus.flag_c;
`endif

  assign mem_wait     = (state == S_F1) ||
                        ((state == S_E2) && ((op == OP_LD) || (op == OP_ST)));
  assign wait_expired = (wait_cnt == CNT_W'(MEM_TIMEOUT));

  // State, wait counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state_nxt == state) ? cnt_nxt : '0;
      err_q    <= err_q | timeout;
    end
  end

  // Next state and control decode from state and IR
  always_comb begin
    state_nxt = state;
    cnt_nxt   = wait_cnt;
    timeout   = 1'b0;
    sel_c     = '0;
    rx_c      = '0;
    ir_in_c   = 1'b0;
    a_in_c    = 1'b0;
    g_in_c    = 1'b0;
    add_sub_c = 1'b0;
    pc_incr_c = 1'b0;
    addr_in_c = 1'b0;
    dout_in_c = 1'b0;
    w_d_c     = 1'b0;
    done_c    = 1'b0;

    unique case (state)
      S_IDLE: if (run) state_nxt = S_F0;
      S_F0: begin
        sel_c     = SEL_W'(SEL_PC);
        addr_in_c = 1'b1;
        pc_incr_c = 1'b1;
        state_nxt = S_F1;
      end
      S_F1: state_nxt = S_F2;
      S_F2: begin
        ir_in_c   = 1'b1;
        state_nxt = S_E1;
      end
      S_E1: begin
        state_nxt = S_E2;
        case (op)
          OP_MV: begin
            sel_c  = sel_y;
            rx_c   = rx_x;
            done_c = 1'b1;
          end
          OP_MVT: begin
            sel_c  = SEL_W'(SEL_HI);
            rx_c   = rx_x;
            done_c = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            sel_c  = SEL_W'(x);
            a_in_c = 1'b1;
          end
          OP_LD, OP_ST: begin
            sel_c     = SEL_W'(y);
            addr_in_c = 1'b1;
          end
          OP_B: begin
            if (taken) begin
              sel_c = SEL_W'(SEL_IMM);
              rx_c  = 8'h80;
            end
            done_c = 1'b1;
          end
          default: done_c = 1'b1;
        endcase
      end
      S_E2: begin
        state_nxt = S_E3;
        case (op)
          OP_ADD, OP_SUB: begin
            sel_c     = sel_y;
            g_in_c    = 1'b1;
            add_sub_c = (op == OP_SUB);
          end
          OP_ST: begin
            sel_c     = SEL_W'(x);
            dout_in_c = 1'b1;
            w_d_c     = 1'b1;
            done_c    = bus.mem_ready;
          end
          OP_LD:   ;
          default: state_nxt = S_IDLE;
        endcase
      end
      S_E3: begin
        state_nxt = S_IDLE;
        if ((op == OP_ADD) || (op == OP_SUB)) begin
          sel_c  = SEL_W'(SEL_G);
          rx_c   = rx_x;
          done_c = 1'b1;
        end else if (op == OP_LD) begin
          sel_c  = SEL_W'(SEL_DIN);
          rx_c   = rx_x;
          done_c = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // A stalled memory wait holds the state; mem_ready on the limit cycle still wins
    if (mem_wait && !bus.mem_ready) begin
      if (wait_expired) begin
        timeout   = 1'b1;
        state_nxt = S_IDLE;
      end else begin
        state_nxt = state;
        cnt_nxt   = wait_cnt + CNT_W'(1);
      end
    end

    if (done_c) state_nxt = run ? S_F0 : S_IDLE;
  end

  assign bus.sel          = sel_c;
  assign bus.RX_in        = rx_c;
  assign bus.IR_in        = ir_in_c;
  assign bus.A_in         = a_in_c;
  assign bus.G_in         = g_in_c;
  assign bus.add_sub_ctrl = add_sub_c;
  assign bus.pc_incr      = pc_incr_c;
  assign bus.ADDR_in      = addr_in_c;
  assign bus.DOUT_in      = dout_in_c;
  assign bus.W_D          = w_d_c;
  assign bus.done         = done_c;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// Bench for proc_sequencer: directed literal checks, then randomized traffic
// compared every cycle against a step-table model of the instruction timing.
module tb_proc_sequencer;

  localparam int unsigned T = 15;

  localparam int PH_IDLE = 0;
  localparam int PH_FA   = 1;
  localparam int PH_FW   = 2;
  localparam int PH_FL   = 3;
  localparam int PH_X1   = 4;
  localparam int PH_X2   = 5;
  localparam int PH_X3   = 6;

  logic clk = 1'b0;
  logic reset_n;
  logic run;

  proc_sequencer_if #(.SEL_W(4)) bus ();

  proc_sequencer #(.MEM_TIMEOUT(T), .SEL_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (run),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  int ph      = PH_IDLE;
  int wc      = 0;
  bit err_m   = 1'b0;
  bit synced  = 1'b0;
  int stall   = 0;

  logic [20:0] dvec;
  assign dvec = {bus.sel, bus.RX_in, bus.IR_in, bus.A_in, bus.G_in, bus.add_sub_ctrl,
                 bus.pc_incr, bus.ADDR_in, bus.DOUT_in, bus.W_D, bus.done};

  function automatic bit br_taken(logic [2:0] c, logic fz, logic fc);
`ifdef COND_BRANCH_EN
    bit tbl [8];
    tbl = '{1'b1, fz, !fz, !fc, fc, 1'b0, 1'b0, 1'b0};
    return tbl[c];
`else
    return 1'b1;
`endif
  endfunction

  // Expected control word for a phase of the current instruction
  function automatic logic [20:0] expect_vec(int p, logic [15:0] ir, logic rdy,
                                             logic fz, logic fc);
    int op, xr, yr, ysel;
    int s;
    logic [7:0] rx;
    logic irin, ain, gin, asub, pc, addr, dout, wd, dn;
    op = int'(ir[15:13]);
    xr = int'(ir[11:9]);
    yr = int'(ir[2:0]);
    ysel = ir[12] ? 8 : yr;
    s = 0; rx = 8'h00;
    {irin, ain, gin, asub, pc, addr, dout, wd, dn} = 9'b0;
    if (p == PH_FA) begin
      s = 7; addr = 1'b1; pc = 1'b1;
    end else if (p == PH_FL) begin
      irin = 1'b1;
    end else if (p == PH_X1) begin
      if (op == 0)      begin s = ysel; rx = 8'(1 << xr); dn = 1'b1; end
      else if (op == 1) begin s = 11;   rx = 8'(1 << xr); dn = 1'b1; end
      else if (op == 2 || op == 3) begin s = xr; ain = 1'b1; end
      else if (op == 4 || op == 5) begin s = yr; addr = 1'b1; end
      else if (op == 6) dn = 1'b1;
      else begin
        if (br_taken(ir[11:9], fz, fc)) begin s = 8; rx = 8'h80; end
        dn = 1'b1;
      end
    end else if (p == PH_X2) begin
      if (op == 2 || op == 3) begin s = ysel; gin = 1'b1; asub = (op == 3); end
      else if (op == 5) begin s = xr; dout = 1'b1; wd = 1'b1; dn = rdy; end
    end else if (p == PH_X3) begin
      s  = (op == 4) ? 10 : 9;
      rx = 8'(1 << xr);
      dn = 1'b1;
    end
    return {4'(s), rx, irin, ain, gin, asub, pc, addr, dout, wd, dn};
  endfunction

  // Model advance on each rising edge
  always @(posedge clk) begin
    logic [20:0] v;
    int np, op;
    bit waiting;
    v  = expect_vec(ph, bus.IR_out, bus.mem_ready, bus.flag_z, bus.flag_c);
    op = int'(bus.IR_out[15:13]);
    if (!reset_n) begin
      ph = PH_IDLE; wc = 0; err_m = 1'b0; synced = 1'b1;
    end else begin
      waiting = (ph == PH_FW) || (ph == PH_X2 && (op == 4 || op == 5));
      np = (ph == PH_IDLE) ? (run ? PH_FA : PH_IDLE) :
           (ph == PH_X3)   ? PH_IDLE : ph + 1;
      if (waiting && !bus.mem_ready) begin
        if (wc == int'(T)) begin np = PH_IDLE; err_m = 1'b1; end
        else np = ph;
      end
      if (v[0]) np = run ? PH_FA : PH_IDLE;
      if (np != ph) wc = 0;
      else if (waiting && !bus.mem_ready) wc = wc + 1;
      ph = np;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic [20:0] e;
    if (synced) begin
      e = expect_vec(ph, bus.IR_out, bus.mem_ready, bus.flag_z, bus.flag_c);
      vectors++;
      if (dvec !== e) begin
        miscompares++;
        $display("FAIL ctrl_word t=%0t phase=%0d ir=%h: got %h want %h", $time, ph, bus.IR_out, dvec, e);
      end
      vectors++;
      if (bus.err !== err_m) begin
        miscompares++;
        $display("FAIL err_flag t=%0t: got %b want %b", $time, bus.err, err_m);
      end
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch3();
    cyc(); cyc(); cyc();
  endtask

  initial begin
    reset_n = 1'b0; run = 1'b0;
    bus.IR_out = 16'h0000; bus.mem_ready = 1'b1; bus.flag_z = 1'b0; bus.flag_c = 1'b0;
    repeat (2) cyc();
    chk("reset_outputs", 32'(dvec), 0);
    chk("reset_err", 32'(bus.err), 0);

    // mv R2,#5
    reset_n = 1'b1; run = 1'b1; bus.IR_out = 16'h1405;
    cyc();
    chk("f0_sel", 32'(bus.sel), 7);
    chk("f0_addr_in", 32'(bus.ADDR_in), 1);
    chk("f0_pc_incr", 32'(bus.pc_incr), 1);
    cyc(); cyc();
    chk("f2_ir_in", 32'(bus.IR_in), 1);
    cyc();
    chk("mv_sel", 32'(bus.sel), 8);
    chk("mv_rx", 32'(bus.RX_in), 32'h04);
    chk("mv_done", 32'(bus.done), 1);

    // add R1,R2
    cyc(); bus.IR_out = 16'h4202;
    fetch3();
    chk("add_e1_sel", 32'(bus.sel), 1);
    chk("add_e1_a_in", 32'(bus.A_in), 1);
    cyc();
    chk("add_e2_sel", 32'(bus.sel), 2);
    chk("add_e2_g_in", 32'(bus.G_in), 1);
    chk("add_e2_addsub", 32'(bus.add_sub_ctrl), 0);
    cyc();
    chk("add_e3_sel", 32'(bus.sel), 9);
    chk("add_e3_rx", 32'(bus.RX_in), 32'h02);
    chk("add_e3_done", 32'(bus.done), 1);

    // ld R3,[R4] with three stalled cycles
    cyc(); bus.IR_out = 16'h8604;
    fetch3();
    chk("ld_e1_sel", 32'(bus.sel), 4);
    chk("ld_e1_addr_in", 32'(bus.ADDR_in), 1);
    bus.mem_ready = 1'b0;
    repeat (4) cyc();
    chk("ld_stall_done", 32'(bus.done), 0);
    bus.mem_ready = 1'b1;
    cyc();
    chk("ld_e3_sel", 32'(bus.sel), 10);
    chk("ld_e3_rx", 32'(bus.RX_in), 32'h08);
    chk("ld_e3_done", 32'(bus.done), 1);

    // fetch timeout
    bus.mem_ready = 1'b0;
    cyc();
    repeat (16) cyc();
    chk("to_err_before", 32'(bus.err), 0);
    cyc();
    chk("to_err_set", 32'(bus.err), 1);
    chk("to_outputs_idle", 32'(dvec), 0);
    run = 1'b0;
    cyc();
    chk("to_err_sticky", 32'(bus.err), 1);

    // sub, then reset during E2
    reset_n = 1'b0; cyc();
    chk("rst_err_clear", 32'(bus.err), 0);
    reset_n = 1'b1; run = 1'b1; bus.mem_ready = 1'b1; bus.IR_out = 16'h6202;
    cyc(); fetch3(); cyc();
    chk("sub_e2_addsub", 32'(bus.add_sub_ctrl), 1);
    chk("sub_e2_g_in", 32'(bus.G_in), 1);
    reset_n = 1'b0; cyc();
    chk("midrst_outputs", 32'(dvec), 0);
    reset_n = 1'b1; cyc();
    chk("restart_f0_sel", 32'(bus.sel), 7);
    chk("restart_f0_pc", 32'(bus.pc_incr), 1);

    // beq 0x010
    reset_n = 1'b0; cyc();
    reset_n = 1'b1; bus.IR_out = 16'hE210; bus.flag_z = 1'b0;
    cyc(); fetch3();
`ifdef COND_BRANCH_EN
    chk("beq_nt_rx", 32'(bus.RX_in), 0);
`else
    chk("b_uncond_rx", 32'(bus.RX_in), 32'h80);
`endif
    chk("beq_nt_done", 32'(bus.done), 1);
    cyc(); bus.flag_z = 1'b1;
    fetch3();
    chk("beq_t_sel", 32'(bus.sel), 8);
    chk("beq_t_rx", 32'(bus.RX_in), 32'h80);
    chk("beq_t_done", 32'(bus.done), 1);

    // randomized traffic
    for (int i = 0; i < 6000; i++) begin
      reset_n = ($urandom_range(0, 299) != 0);
      run     = ($urandom_range(0, 9) != 0);
      if (stall > 0) begin
        bus.mem_ready = 1'b0;
        stall--;
      end else begin
        bus.mem_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 39) == 0) stall = int'($urandom_range(10, 20));
      end
      bus.flag_z = 1'($urandom);
      bus.flag_c = 1'($urandom);
      if (ph == PH_IDLE || ph == PH_FA) bus.IR_out = 16'($urandom);
      cyc();
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
